// File: rtl/mem_access_unit_pkg.sv
// Shared constants and types for the MEM-stage load/store initiator.
package mem_access_unit_pkg;

    // Bus widths
    localparam int DATA_BUS      = 64;
    localparam int DATA_ADDR_BUS = 64;

    // Request direction on the target ports
    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    // Access size codes
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    // Initiator FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mau_state_t;

    // True when the byte address is not a multiple of the access size.
    function automatic logic is_misaligned(input logic [DATA_ADDR_BUS-1:0] addr,
                                           input logic [1:0]               size);
        logic w_mis;
        case (size)
            SIZE_B:  w_mis = 1'b0;
            SIZE_H:  w_mis = addr[0];
            SIZE_W:  w_mis = (addr[1:0] != 2'b00);
            SIZE_D:  w_mis = (addr[2:0] != 3'b000);
            default: w_mis = 1'b0;
        endcase
        return w_mis;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load-data aligner: shifts the addressed bytes of a
// doubleword down to bit 0, truncates to the access size and extends.
// Kept standalone so the I-cache fill path can reuse it.
module mem_load_align
    import mem_access_unit_pkg::*;
(
    input  logic [DATA_BUS-1:0] i_data,
    input  logic [2:0]          i_offset,
    input  logic [1:0]          i_size,
    input  logic                i_unsigned,
    output logic [DATA_BUS-1:0] o_data
);

    logic [DATA_BUS-1:0] w_shifted;

    // Shift by byte offset, then truncate and sign/zero-extend by size.
    always_comb begin
        w_shifted = i_data >> {i_offset, 3'b000};
        o_data    = w_shifted;
        case (i_size)
            SIZE_B: o_data = i_unsigned ? {56'd0, w_shifted[7:0]}
                                        : {{56{w_shifted[7]}}, w_shifted[7:0]};
            SIZE_H: o_data = i_unsigned ? {48'd0, w_shifted[15:0]}
                                        : {{48{w_shifted[15]}}, w_shifted[15:0]};
            SIZE_W: o_data = i_unsigned ? {32'd0, w_shifted[31:0]}
                                        : {{32{w_shifted[31]}}, w_shifted[31:0]};
            default: o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator. Decodes each access to the CLINT port or
// the data-bus port, runs one transaction at a time and stalls the pipeline
// until it completes, times out, or is rejected as misaligned.
//
// Handshake: a target port's valid is held high with all request fields
// stable until the cycle in which that port's ready is high; data_read and
// resp are sampled in that same cycle, and valid is low the cycle after.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter logic [63:0] CLINT_BASE = 64'h0000_0000_0200_0000,
    parameter logic [63:0] CLINT_SIZE = 64'h0000_0000_0001_0000,
    parameter logic [15:0] TIMEOUT    = 16'd1024
) (
    input  logic                     clk,
    input  logic                     rst,
    // Pipeline side
    input  logic                     mem_valid_i,
    input  logic                     mem_is_store_i,
    input  logic [DATA_ADDR_BUS-1:0] mem_addr_i,
    input  logic [1:0]               mem_size_i,
    input  logic                     mem_unsigned_i,
    input  logic [DATA_BUS-1:0]      mem_wdata_i,
    output logic                     mem_stall_o,
    output logic                     mem_done_o,
    output logic [DATA_BUS-1:0]      mem_rdata_o,
    output logic                     mem_err_o,
    // CLINT port
    output logic                     clint_valid_o,
    output logic                     clint_req_o,
    output logic [DATA_ADDR_BUS-1:0] clint_addr_o,
    output logic [1:0]               clint_size_o,
    output logic [DATA_BUS-1:0]      clint_data_write_o,
    input  logic                     clint_ready_i,
    input  logic [DATA_BUS-1:0]      clint_data_read_i,
    input  logic [1:0]               clint_resp_i,
    // Data-bus port
    output logic                     dbus_valid_o,
    output logic                     dbus_req_o,
    output logic [DATA_ADDR_BUS-1:0] dbus_addr_o,
    output logic [1:0]               dbus_size_o,
    output logic [DATA_BUS-1:0]      dbus_data_write_o,
    input  logic                     dbus_ready_i,
    input  logic [DATA_BUS-1:0]      dbus_data_read_i,
    input  logic [1:0]               dbus_resp_i,
    // Debug
    output mau_state_t               dbg_state_o
);

    mau_state_t                r_state;
    mau_state_t                w_next_state;

    logic [DATA_ADDR_BUS-1:0]  r_addr;
    logic [1:0]                r_size;
    logic [DATA_BUS-1:0]       r_wdata;
    logic                      r_is_store;
    logic                      r_unsigned;
    logic                      r_sel_clint;
    logic [15:0]               r_tcnt;
    logic [DATA_BUS-1:0]       r_rdata;
    logic                      r_err;
    logic                      r_after_done;

    logic                      w_accept;
    logic                      w_req_valid;
    logic                      w_stall;
    logic                      w_timeout_hit;
    logic                      w_complete;
    logic                      w_ready;
    logic [DATA_BUS-1:0]       w_data_read;
    logic [1:0]                w_resp;
    logic                      w_in_clint;
    logic                      w_misaligned;
    logic [DATA_BUS-1:0]       w_aligned;
    logic [DATA_BUS-1:0]       w_data_write;

    // Address decode and alignment check on the incoming request.
    assign w_in_clint   = (mem_addr_i >= CLINT_BASE) &&
                          (mem_addr_i < (CLINT_BASE + CLINT_SIZE));
    assign w_misaligned = is_misaligned(mem_addr_i, mem_size_i);

    // Response mux from whichever port this transaction targets.
    assign w_ready     = r_sel_clint ? clint_ready_i     : dbus_ready_i;
    assign w_data_read = r_sel_clint ? clint_data_read_i : dbus_data_read_i;
    assign w_resp      = r_sel_clint ? clint_resp_i      : dbus_resp_i;

    mem_load_align u_load_align (
        .i_data     (w_data_read),
        .i_offset   (r_addr[2:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_aligned)
    );

    // Next-state and control decode.
    always_comb begin
        w_next_state  = r_state;
        w_accept      = 1'b0;
        w_req_valid   = 1'b0;
        w_stall       = 1'b0;
        w_timeout_hit = 1'b0;
        w_complete    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_valid_i) begin
                    // Hold the pipeline even on the guard cycle after DONE,
                    // so the instruction waits rather than slipping past.
                    w_stall = 1'b1;
                    if (!r_after_done) begin
                        w_accept     = 1'b1;
                        w_next_state = w_misaligned ? ST_DONE : ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                w_stall     = 1'b1;
                w_req_valid = 1'b1;
                if (w_ready) begin
                    w_complete   = 1'b1;
                    w_next_state = ST_DONE;
                end else if (r_tcnt == (TIMEOUT - 16'd1)) begin
                    w_timeout_hit = 1'b1;
                    w_next_state  = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latch the request fields and the target select on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_size      <= SIZE_B;
            r_wdata     <= '0;
            r_is_store  <= 1'b0;
            r_unsigned  <= 1'b0;
            r_sel_clint <= 1'b0;
        end else if (w_accept) begin
            r_addr      <= mem_addr_i;
            r_size      <= mem_size_i;
            r_wdata     <= mem_wdata_i;
            r_is_store  <= mem_is_store_i;
            r_unsigned  <= mem_unsigned_i;
            r_sel_clint <= w_in_clint;
        end
    end

    // Ready-timeout counter: cleared on entry to ACCESS, counts waiting cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt <= '0;
        end else if (w_accept) begin
            r_tcnt <= '0;
        end else if (w_req_valid && !w_ready && !w_timeout_hit) begin
            r_tcnt <= r_tcnt + 16'd1;
        end
    end

    // Result registers, loaded on the transition into DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_accept && w_misaligned) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
        end else if (w_complete) begin
            r_rdata <= r_is_store ? '0 : w_aligned;
            r_err   <= (w_resp != 2'b00);
        end else if (w_timeout_hit) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
        end
    end

    // Marks the IDLE cycle right after DONE, in which no request is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_after_done <= 1'b0;
        end else begin
            r_after_done <= (r_state == ST_DONE);
        end
    end

    // Store data is placed on its byte lanes within the doubleword.
    assign w_data_write = r_wdata << {r_addr[2:0], 3'b000};

    // Both ports carry the latched fields; only the selected one sees valid.
    // Valid is also gated by rst so an abandoned transaction drops at once.
    assign clint_valid_o      = w_req_valid &&  r_sel_clint && !rst;
    assign clint_req_o        = r_is_store ? REQ_WRITE : REQ_READ;
    assign clint_addr_o       = r_addr;
    assign clint_size_o       = r_size;
    assign clint_data_write_o = w_data_write;

    assign dbus_valid_o       = w_req_valid && !r_sel_clint && !rst;
    assign dbus_req_o         = r_is_store ? REQ_WRITE : REQ_READ;
    assign dbus_addr_o        = r_addr;
    assign dbus_size_o        = r_size;
    assign dbus_data_write_o  = w_data_write;

    assign mem_stall_o = w_stall;
    assign mem_done_o  = (r_state == ST_DONE);
    assign mem_rdata_o = r_rdata;
    assign mem_err_o   = r_err && (r_state == ST_DONE);
    assign dbg_state_o = r_state;

endmodule
